sd_1001_moore: RTL and testbench



---
 rtl/sd_1001_moore_pkg.sv | 15 +
 rtl/sd_1001_moore.sv | 42 ++++
 tb/tb_sd_1001_moore.sv | 114 +++++++++++
 3 files changed

// File: rtl/sd_1001_moore_pkg.sv
// Shared types for the 1001 Moore sequence detector.
package sd_1001_moore_pkg;

  localparam int unsigned STATE_W = 3;

  // Each state names the longest prefix of 1001 matched so far.
  typedef enum logic [STATE_W-1:0] {
    IDLE  = 3'd0,
    S1    = 3'd1,
    S10   = 3'd2,
    S100  = 3'd3,
    S1001 = 3'd4
  } state_t;

endpackage

// File: rtl/sd_1001_moore.sv
// Moore detector for the serial pattern 1-0-0-1 with overlap; out is decoded
// from the state register only, so it is glitch-free and one cycle wide.
module sd_1001_moore
  import sd_1001_moore_pkg::*;
(
  input  logic clk,
  input  logic reset,
  input  logic in,
  output logic out
);

  state_t state;
  state_t next_state;

  // State register; synchronous reset takes priority over the data bit.
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= next_state;
    end
  end

  // Next-state and output decode; unused encodings fall back to IDLE.
  always_comb begin
    next_state = IDLE;
    out        = 1'b0;
    unique case (state)
      IDLE:    next_state = in ? S1    : IDLE;
      S1:      next_state = in ? S1    : S10;
      S10:     next_state = in ? S1    : S100;
      S100:    next_state = in ? S1001 : IDLE;
      S1001: begin
        out        = 1'b1;
        // Final 1 of a match is reused as the leading 1 of the next one.
        next_state = in ? S1 : S10;
      end
      default: next_state = IDLE;
    endcase
  end

endmodule

// File: tb/tb_sd_1001_moore.sv
// Directed and random self-checking bench for sd_1001_moore.
module tb_sd_1001_moore;
  import sd_1001_moore_pkg::*;

  logic clk;
  logic reset;
  logic in;
  logic out;

  int checks   = 0;
  int failures = 0;

  sd_1001_moore dut (
    .clk   (clk),
    .reset (reset),
    .in    (in),
    .out   (out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_out(input logic exp, input string tag);
    checks++;
    assert (out === exp) else begin
      failures++;
      $error("FAIL %s observed=%0b expected=%0b", tag, out, exp);
    end
  endtask

  // Drive one bit ahead of the edge, then sample #1 after it.
  task automatic step(input logic b, input logic exp, input string tag);
    @(negedge clk);
    reset = 1'b0;
    in    = b;
    @(posedge clk);
    #1;
    check_out(exp, tag);
  endtask

  task automatic do_reset(input int edges);
    for (int i = 0; i < edges; i++) begin
      @(negedge clk);
      reset = 1'b1;
      in    = logic'(i % 2 == 0);
      @(posedge clk);
      #1;
      check_out(1'b0, "reset_out");
      checks++;
      assert (dut.state === IDLE) else begin
        failures++;
        $error("FAIL reset_state observed=%0d expected=%0d", dut.state, IDLE);
      end
    end
    @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic run_seq(input logic [15:0] bits, input logic [15:0] exp,
                         input int len, input string tag);
    for (int i = len - 1; i >= 0; i--) begin
      step(bits[i], exp[i], tag);
    end
  endtask

  logic [3:0] hist;
  logic       b;

  initial begin
    reset = 1'b1;
    in    = 1'b0;

    do_reset(3);

    // Basic match, then one trailing 0 to confirm the pulse drops.
    run_seq(16'b1001_0, 16'b0001_0, 5, "basic");

    do_reset(1);
    run_seq(16'b1001001, 16'b0001001, 7, "overlap");

    do_reset(1);
    run_seq(16'b101001, 16'b000001, 6, "near_101001");

    do_reset(1);
    run_seq(16'b10001, 16'b00000, 5, "near_10001");

    do_reset(1);
    run_seq(16'b11001, 16'b00001, 5, "near_11001");

    // Reset in the middle of a prefix discards it, even with in=1 at reset.
    do_reset(1);
    run_seq(16'b100, 16'b000, 3, "mid_pre");
    @(negedge clk);
    reset = 1'b1;
    in    = 1'b1;
    @(posedge clk);
    #1;
    check_out(1'b0, "mid_reset");
    run_seq(16'b1001, 16'b0001, 4, "mid_post");

    // Random soak against a 4-bit history model.
    do_reset(1);
    hist = 4'b0000;
    for (int i = 0; i < 2000; i++) begin
      b    = 1'($urandom_range(0, 1));
      hist = {hist[2:0], b};
      step(b, logic'(hist == 4'b1001), "soak");
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
